// File: rtl/ma_stage_if.sv
// Data-memory request/response bus between the MA stage and data memory.
interface ma_stage_if;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic [3:0]  dmem_be;
   logic [31:0] dmem_rdata;
   logic        dmem_ack;

   modport master (
      output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
      input  dmem_rdata, dmem_ack
   );

   modport slave (
      input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
      output dmem_rdata, dmem_ack
   );
endinterface

// File: rtl/ma_stage.sv
// Memory-access pipeline stage: issues aligned loads/stores over a req/ack bus,
// stalls upstream until completion and formats load data for write-back.
module ma_stage (
   input  logic              CLK,
   input  logic              RST,
   input  logic              EX_MemR,
   input  logic              EX_MemW,
   input  logic [1:0]        EX_MemSize,
   input  logic              EX_MemSigned,
   input  logic [31:0]       EX_ALUOut,
   input  logic [31:0]       EX_WData,
   input  logic              EX_MemToReg,
   input  logic              EX_JAL,
   input  logic              EX_RegW,
   input  logic              EX_RegDst,
   input  logic              EX_OF,
   input  logic [31:0]       EX_NPC1,
   input  logic [31:0]       EX_IR,
   output logic              MA_MemToReg,
   output logic              MA_JAL,
   output logic              MA_RegW,
   output logic              MA_RegDst,
   output logic              MA_OF,
   output logic [31:0]       MA_NPC1,
   output logic [31:0]       MA_ALUOut,
   output logic [31:0]       MA_MemOut,
   output logic [31:0]       MA_IR,
   output logic              MA_Stall,
   output logic              MA_AddrErr,
   ma_stage_if.master        dmem
);

   typedef enum logic [0:0] {StIdle, StReq} state_e;

   state_e      state_q;
   logic        req_q;
   logic        we_q;
   logic [3:0]  be_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [1:0]  size_q;
   logic        sext_q;
   logic [1:0]  lo_q;

   logic        aligned;
   logic        access;
   logic [3:0]  be_d;
   logic [31:0] wdata_d;
   logic [15:0] lane_h;
   logic [7:0]  lane_b;
   logic [31:0] load_val;

   always_comb begin
      aligned = 1'b1;
      be_d    = 4'b1111;
      wdata_d = EX_WData;
      case (EX_MemSize)
         2'b00: begin
            aligned = 1'b1;
            be_d    = 4'b0001 << EX_ALUOut[1:0];
            wdata_d = {4{EX_WData[7:0]}};
         end
         2'b01: begin
            aligned = ~EX_ALUOut[0];
            be_d    = EX_ALUOut[1] ? 4'b1100 : 4'b0011;
            wdata_d = {2{EX_WData[15:0]}};
         end
         default: begin
            aligned = (EX_ALUOut[1:0] == 2'b00);
            be_d    = 4'b1111;
            wdata_d = EX_WData;
         end
      endcase
   end

   assign access     = (EX_MemR | EX_MemW) & aligned;
   assign MA_AddrErr = (EX_MemR | EX_MemW) & ~aligned;
   assign MA_Stall   = ((state_q == StIdle) & access) | ((state_q == StReq) & ~dmem.dmem_ack);

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= StIdle;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         be_q    <= 4'b0000;
         addr_q  <= 32'h0;
         wdata_q <= 32'h0;
         size_q  <= 2'b00;
         sext_q  <= 1'b0;
         lo_q    <= 2'b00;
      end else begin
         case (state_q)
            StIdle: begin
               if (access) begin
                  state_q <= StReq;
                  req_q   <= 1'b1;
                  we_q    <= EX_MemW;
                  be_q    <= be_d;
                  addr_q  <= {EX_ALUOut[31:2], 2'b00};
                  wdata_q <= wdata_d;
                  size_q  <= EX_MemSize;
                  sext_q  <= EX_MemSigned;
                  lo_q    <= EX_ALUOut[1:0];
               end
            end
            StReq: begin
               // Address/data/enables stay latched; only the strobes drop on ack.
               if (dmem.dmem_ack) begin
                  state_q <= StIdle;
                  req_q   <= 1'b0;
                  we_q    <= 1'b0;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign dmem.dmem_req   = req_q;
   assign dmem.dmem_we    = we_q;
   assign dmem.dmem_be    = be_q;
   assign dmem.dmem_addr  = addr_q;
   assign dmem.dmem_wdata = wdata_q;

   always_comb begin
      lane_h = lo_q[1] ? dmem.dmem_rdata[31:16] : dmem.dmem_rdata[15:0];
      lane_b = dmem.dmem_rdata[7:0];
      case (lo_q)
         2'b00:   lane_b = dmem.dmem_rdata[7:0];
         2'b01:   lane_b = dmem.dmem_rdata[15:8];
         2'b10:   lane_b = dmem.dmem_rdata[23:16];
         default: lane_b = dmem.dmem_rdata[31:24];
      endcase
      case (size_q)
         2'b00:   load_val = {{24{sext_q & lane_b[7]}}, lane_b};
         2'b01:   load_val = {{16{sext_q & lane_h[15]}}, lane_h};
         default: load_val = dmem.dmem_rdata;
      endcase
   end

   assign MA_MemOut = ((state_q == StReq) && dmem.dmem_ack && !we_q) ? load_val : 32'h0;

   assign MA_MemToReg = EX_MemToReg;
   assign MA_JAL      = EX_JAL;
   assign MA_RegDst   = EX_RegDst;
   assign MA_OF       = EX_OF;
   assign MA_NPC1     = EX_NPC1;
   assign MA_ALUOut   = EX_ALUOut;
   assign MA_IR       = EX_IR;
   assign MA_RegW     = EX_RegW & ~MA_Stall & ~MA_AddrErr;

endmodule

// File: tb/tb_ma_stage.sv
// Self-checking bench for ma_stage: bench-driven memory responder with a
// scoreboard of expected bus fields and load results.
module tb_ma_stage;

   logic        CLK;
   logic        RST;
   logic        EX_MemR, EX_MemW, EX_MemSigned;
   logic [1:0]  EX_MemSize;
   logic [31:0] EX_ALUOut, EX_WData, EX_NPC1, EX_IR;
   logic        EX_MemToReg, EX_JAL, EX_RegW, EX_RegDst, EX_OF;
   logic        MA_MemToReg, MA_JAL, MA_RegW, MA_RegDst, MA_OF;
   logic [31:0] MA_NPC1, MA_ALUOut, MA_MemOut, MA_IR;
   logic        MA_Stall, MA_AddrErr;

   ma_stage_if dmem_bus ();

   ma_stage u_dut (
      .CLK          (CLK),
      .RST          (RST),
      .EX_MemR      (EX_MemR),
      .EX_MemW      (EX_MemW),
      .EX_MemSize   (EX_MemSize),
      .EX_MemSigned (EX_MemSigned),
      .EX_ALUOut    (EX_ALUOut),
      .EX_WData     (EX_WData),
      .EX_MemToReg  (EX_MemToReg),
      .EX_JAL       (EX_JAL),
      .EX_RegW      (EX_RegW),
      .EX_RegDst    (EX_RegDst),
      .EX_OF        (EX_OF),
      .EX_NPC1      (EX_NPC1),
      .EX_IR        (EX_IR),
      .MA_MemToReg  (MA_MemToReg),
      .MA_JAL       (MA_JAL),
      .MA_RegW      (MA_RegW),
      .MA_RegDst    (MA_RegDst),
      .MA_OF        (MA_OF),
      .MA_NPC1      (MA_NPC1),
      .MA_ALUOut    (MA_ALUOut),
      .MA_MemOut    (MA_MemOut),
      .MA_IR        (MA_IR),
      .MA_Stall     (MA_Stall),
      .MA_AddrErr   (MA_AddrErr),
      .dmem         (dmem_bus.master)
   );

   typedef struct {
      logic [31:0] memout;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      logic        we;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [3:0] model_be(input logic [1:0] sz, input logic [31:0] a);
      case (sz)
         2'b00:   return 4'b0001 << a[1:0];
         2'b01:   return a[1] ? 4'b1100 : 4'b0011;
         default: return 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] model_wdata(input logic [1:0] sz, input logic [31:0] wd);
      case (sz)
         2'b00:   return {4{wd[7:0]}};
         2'b01:   return {2{wd[15:0]}};
         default: return wd;
      endcase
   endfunction

   function automatic logic [31:0] model_load(input logic [1:0] sz, input logic sg,
                                              input logic [1:0] lo, input logic [31:0] rd);
      logic [31:0] s;
      s = rd >> {lo, 3'b000};
      case (sz)
         2'b00:   return sg ? {{24{s[7]}}, s[7:0]} : {24'h0, s[7:0]};
         2'b01:   return sg ? {{16{s[15]}}, s[15:0]} : {16'h0, s[15:0]};
         default: return rd;
      endcase
   endfunction

   task automatic idle_inputs();
      EX_MemR = 1'b0; EX_MemW = 1'b0; EX_RegW = 1'b0;
      dmem_bus.dmem_ack = 1'b0;
   endtask

   // One aligned access; memory acks after 'waits' non-ack REQ cycles.
   task automatic run_access(input logic r, input logic w, input logic [1:0] sz, input logic sg,
                             input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                             input int waits);
      exp_t        e;
      int          stalls;
      logic [31:0] ir, npc;
      e.we     = w;
      e.be     = model_be(sz, a);
      e.addr   = {a[31:2], 2'b00};
      e.wdata  = model_wdata(sz, wd);
      e.memout = w ? 32'h0 : model_load(sz, sg, a[1:0], rd);
      sb_q.push_back(e);
      ir  = $urandom;
      npc = $urandom;
      @(posedge CLK); #1;
      EX_MemR = r; EX_MemW = w; EX_MemSize = sz; EX_MemSigned = sg;
      EX_ALUOut = a; EX_WData = wd; EX_RegW = 1'b1; EX_IR = ir; EX_NPC1 = npc;
      dmem_bus.dmem_ack = 1'b0; dmem_bus.dmem_rdata = $urandom;
      @(negedge CLK);
      stalls = int'(MA_Stall);
      check("idle_req", dmem_bus.dmem_req, 1'b0);
      check("idle_regw", MA_RegW, 1'b0);
      check("idle_addrerr", MA_AddrErr, 1'b0);
      for (int i = 0; i <= waits; i++) begin
         @(posedge CLK); #1;
         dmem_bus.dmem_ack   = (i == waits);
         dmem_bus.dmem_rdata = (i == waits) ? rd : $urandom;
         @(negedge CLK);
         stalls += int'(MA_Stall);
         check("req", dmem_bus.dmem_req, 1'b1);
         check("addr", dmem_bus.dmem_addr, sb_q[0].addr);
         check("be", {28'h0, dmem_bus.dmem_be}, {28'h0, sb_q[0].be});
         check("wdata", dmem_bus.dmem_wdata, sb_q[0].wdata);
         check("we", dmem_bus.dmem_we, sb_q[0].we);
         if (i == waits) begin
            e = sb_q.pop_front();
            check("memout", MA_MemOut, e.memout);
            check("regw_ack", MA_RegW, 1'b1);
            check("ir_pass", MA_IR, ir);
            check("npc_pass", MA_NPC1, npc);
         end else begin
            check("memout_wait", MA_MemOut, 32'h0);
         end
      end
      check("stall_cycles", stalls, waits + 1);
      @(posedge CLK); #1;
      idle_inputs();
      @(negedge CLK);
      check("req_drop", dmem_bus.dmem_req, 1'b0);
      check("stall_idle", MA_Stall, 1'b0);
   endtask

   initial begin
      RST = 1'b1;
      EX_MemSize = 2'b10; EX_MemSigned = 1'b0; EX_ALUOut = 32'h0; EX_WData = 32'h0;
      EX_MemToReg = 1'b1; EX_JAL = 1'b0; EX_RegDst = 1'b1; EX_OF = 1'b0;
      EX_NPC1 = 32'h0; EX_IR = 32'h0; dmem_bus.dmem_rdata = 32'h0;
      idle_inputs();
      repeat (2) @(negedge CLK);
      check("rst_req", dmem_bus.dmem_req, 1'b0);
      check("rst_we", dmem_bus.dmem_we, 1'b0);
      check("rst_be", {28'h0, dmem_bus.dmem_be}, 32'h0);
      check("rst_addr", dmem_bus.dmem_addr, 32'h0);
      check("rst_wdata", dmem_bus.dmem_wdata, 32'h0);
      check("rst_stall", MA_Stall, 1'b0);
      check("rst_memout", MA_MemOut, 32'h0);
      @(posedge CLK); #1;
      RST = 1'b0;

      run_access(1, 0, 2'b10, 0, 32'h100, 32'h0, 32'hDEADBEEF, 0);          // lw
      run_access(1, 0, 2'b00, 1, 32'h103, 32'h0, 32'h80112233, 0);          // lb
      run_access(1, 0, 2'b00, 0, 32'h103, 32'h0, 32'h80112233, 1);          // lbu
      run_access(0, 1, 2'b01, 0, 32'h202, 32'h0000ABCD, 32'h0, 3);          // sh
      run_access(1, 1, 2'b10, 0, 32'h10, 32'h11223344, 32'h55667788, 0);    // both -> store
      run_access(1, 0, 2'b01, 1, 32'h102, 32'h0, 32'h80017FFF, 0);          // lh upper
      run_access(1, 0, 2'b01, 0, 32'h100, 32'h0, 32'h80017FFF, 2);          // lhu lower
      run_access(0, 1, 2'b00, 0, 32'h001, 32'h12345678, 32'h0, 1);          // sb
      run_access(1, 0, 2'b11, 1, 32'h44, 32'h0, 32'hCAFEF00D, 0);           // size 11 as word

      // Misaligned accesses: flag only, no request, no stall, bubble into WB.
      for (int k = 0; k < 2; k++) begin
         @(posedge CLK); #1;
         EX_MemR = 1'b1; EX_MemW = 1'b0; EX_RegW = 1'b1;
         EX_MemSize = (k == 0) ? 2'b10 : 2'b01;
         EX_ALUOut = (k == 0) ? 32'h101 : 32'h203;
         dmem_bus.dmem_ack = 1'b1; dmem_bus.dmem_rdata = 32'hFFFFFFFF;
         @(negedge CLK);
         check("mis_err", MA_AddrErr, 1'b1);
         check("mis_stall", MA_Stall, 1'b0);
         check("mis_regw", MA_RegW, 1'b0);
         check("mis_memout", MA_MemOut, 32'h0);
         @(negedge CLK);
         check("mis_req", dmem_bus.dmem_req, 1'b0);
      end
      @(posedge CLK); #1;
      idle_inputs();

      // Reset while a load is outstanding; the late ack must be ignored.
      @(posedge CLK); #1;
      EX_MemR = 1'b1; EX_MemW = 1'b0; EX_MemSize = 2'b10; EX_ALUOut = 32'h40; EX_RegW = 1'b1;
      @(posedge CLK); #1;
      @(negedge CLK);
      check("abort_req_before", dmem_bus.dmem_req, 1'b1);
      #2;
      RST = 1'b1;
      idle_inputs();
      #1;
      check("abort_req_async", dmem_bus.dmem_req, 1'b0);
      check("abort_addr", dmem_bus.dmem_addr, 32'h0);
      @(posedge CLK); #1;
      RST = 1'b0;
      dmem_bus.dmem_ack = 1'b1; dmem_bus.dmem_rdata = 32'h12345678;
      @(negedge CLK);
      check("late_ack_req", dmem_bus.dmem_req, 1'b0);
      check("late_ack_stall", MA_Stall, 1'b0);
      check("late_ack_memout", MA_MemOut, 32'h0);
      @(posedge CLK); #1;
      dmem_bus.dmem_ack = 1'b0;
      @(negedge CLK);
      check("late_ack_idle", dmem_bus.dmem_req, 1'b0);

      run_access(1, 0, 2'b10, 0, 32'h300, 32'h0, 32'h0BADF00D, 1);          // first after reset

      for (int n = 0; n < 8; n++) begin
         logic [1:0]  sz;
         logic [31:0] a;
         logic        w;
         sz = 2'($urandom_range(0, 3));
         a  = $urandom;
         if (sz == 2'b01) a[0] = 1'b0;
         if (sz[1]) a[1:0] = 2'b00;
         w  = 1'($urandom_range(0, 1));
         run_access(~w, w, sz, 1'($urandom_range(0, 1)), a, $urandom, $urandom,
                    int'($urandom_range(0, 3)));
      end

      check("sb_empty", sb_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
